// File: rtl/clz_pkg.sv
// Shared helpers for the count-leading-zeros unit: width math and default sizing.
package clz_pkg;

    // Ceiling log2; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Smallest power of two that is >= n.
    function automatic int unsigned next_pow2(input int unsigned n);
        int unsigned v;
        v = 1;
        while (v < n) begin
            v = v << 1;
        end
        return v;
    endfunction

    // Tree level whose outputs get the optional mid-tree register: roughly halfway down.
    function automatic int unsigned pipe_cut(input int unsigned levels);
        return (levels > 1) ? (levels / 2) - 1 : 0;
    endfunction

    localparam int unsigned DefaultBitsIn   = 8;
    localparam int unsigned DefaultPadWidth = next_pow2(DefaultBitsIn);
    localparam int unsigned DefaultCntWidth = clog2(DefaultPadWidth);

endpackage

// File: rtl/clz_clk_node.sv
// Combinational merge node of the leading-zero tree: joins a left (more significant)
// and a right half, each carrying a valid flag and an m-bit count.
module clz_node #(
    parameter int unsigned m = 1
) (
    input  logic         vl,
    input  logic [m-1:0] cl,
    input  logic         vr,
    input  logic [m-1:0] cr,
    output logic         v,
    output logic [m:0]   count
);

    // If the left half holds a 1 its count stands; otherwise the whole left half is
    // zeros, which adds 2^m to the right half's count.
    always_comb begin
        v     = vl | vr;
        count = vl ? {1'b0, cl} : {1'b1, cr};
    end

endmodule

// File: rtl/clz_clk.sv
// Registered count-leading-zeros unit. Result and any-bit-set flag appear one cycle
// after b is sampled. Defining CLZ_CLK_PIPE_EN adds a mid-tree register (latency 2).
module clz_clk
    import clz_pkg::*;
#(
    parameter int unsigned bits_in = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [bits_in-1:0]         b,
    output logic                       vout,
    output logic [clog2(bits_in)-1:0]  pout
);

    localparam int unsigned P   = next_pow2(bits_in);
    localparam int unsigned L   = clog2(P);
    localparam int unsigned W   = clog2(bits_in);
    localparam int unsigned Cut = pipe_cut(L);

    logic [P-1:0] b_pad;

    // Pad at the LSB end so zeros below the real bits never change a nonzero count.
    always_comb begin
        b_pad                  = '0;
        b_pad[P-1 -: bits_in]  = b;
    end

    // Level k has P >> (k+1) nodes, each with a (k+1)-bit count. Index 0 is the most
    // significant node of its level.
    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int unsigned N = P >> (k + 1);

        logic [N-1:0] v;
        logic [k:0]   c   [N];
        logic [N-1:0] v_s;
        logic [k:0]   c_s [N];

        if (k == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_pair
                assign v[j] = |b_pad[P-1-2*j -: 2];
                assign c[j] = ~b_pad[P-1-2*j];
            end
        end else begin : g_merge
            for (genvar j = 0; j < N; j++) begin : g_node
                clz_node #(
                    .m(k)
                ) u_node (
                    .vl    (g_lvl[k-1].v_s[2*j]),
                    .cl    (g_lvl[k-1].c_s[2*j]),
                    .vr    (g_lvl[k-1].v_s[2*j+1]),
                    .cr    (g_lvl[k-1].c_s[2*j+1]),
                    .v     (v[j]),
                    .count (c[j])
                );
            end
        end

`ifdef CLZ_CLK_PIPE_EN
        if (k == Cut) begin : g_stage
            // Mid-tree register splitting the combinational depth across two cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_s <= '0;
                    for (int j = 0; j < N; j++) begin
                        c_s[j] <= '0;
                    end
                end else begin
                    v_s <= v;
                    for (int j = 0; j < N; j++) begin
                        c_s[j] <= c[j];
                    end
                end
            end
        end else begin : g_pass
            assign v_s = v;
            for (genvar j = 0; j < N; j++) begin : g_wire
                assign c_s[j] = c[j];
            end
        end
`else
        assign v_s = v;
        for (genvar j = 0; j < N; j++) begin : g_wire
            assign c_s[j] = c[j];
        end
`endif
    end

    logic         v_root;
    logic [L-1:0] c_root;

    assign v_root = g_lvl[L-1].v_s[0];
    assign c_root = g_lvl[L-1].c_s[0];

    // Output register; an all-zero vector reports count 0 rather than the tree's all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout <= 1'b0;
            pout <= '0;
        end else begin
            vout <= v_root;
            pout <= v_root ? c_root[W-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_clz_clk.sv
// Directed and random checks of clz_clk at widths 4, 6 (padded) and 8.
module tb_clz_clk;

`ifdef CLZ_CLK_PIPE_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] b4  = '0;
    logic [5:0] b6  = '0;
    logic [7:0] b8  = '0;
    logic       v4, v6, v8;
    logic [1:0] p4;
    logic [2:0] p6, p8;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {vout, pout} per DUT, delayed by the DUT latency.
    logic [3:0] pipe4 [Lat];
    logic [3:0] pipe6 [Lat];
    logic [3:0] pipe8 [Lat];

    clz_clk #(.bits_in(4)) u_dut4 (.clk(clk), .rst(rst), .b(b4), .vout(v4), .pout(p4));
    clz_clk #(.bits_in(6)) u_dut6 (.clk(clk), .rst(rst), .b(b6), .vout(v6), .pout(p6));
    clz_clk #(.bits_in(8)) u_dut8 (.clk(clk), .rst(rst), .b(b8), .vout(v8), .pout(p8));

    always #5 clk = ~clk;

    // Reference: scan from the MSB down; all-zero gives {0, 0}.
    function automatic logic [3:0] ref_clz(input logic [7:0] x, input int w);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) found = 1'b1;
                else n++;
            end
        end
        return found ? {1'b1, 3'(n)} : 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed {v,p}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle: r, the three inputs and the expected {v,p} for them; then clock
    // and compare outputs against the expectation that has reached the output stage.
    task automatic step(input string tag, input logic r,
                        input logic [3:0] x4, input logic [5:0] x6, input logic [7:0] x8,
                        input logic [3:0] h4, input logic [3:0] h6, input logic [3:0] h8);
        rst = r;
        b4  = x4;
        b6  = x6;
        b8  = x8;
        for (int i = Lat - 1; i > 0; i--) begin
            pipe4[i] = pipe4[i-1];
            pipe6[i] = pipe6[i-1];
            pipe8[i] = pipe8[i-1];
        end
        pipe4[0] = h4;
        pipe6[0] = h6;
        pipe8[0] = h8;
        if (r) begin
            for (int i = 0; i < Lat; i++) begin
                pipe4[i] = '0;
                pipe6[i] = '0;
                pipe8[i] = '0;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "/w4"}, {v4, 1'b0, p4}, pipe4[Lat-1]);
        check({tag, "/w6"}, {v6, p6}, pipe6[Lat-1]);
        check({tag, "/w8"}, {v8, p8}, pipe8[Lat-1]);
    endtask

    initial begin
        logic [3:0] x4;
        logic [5:0] x6;
        logic [7:0] x8;

        for (int i = 0; i < Lat; i++) begin
            pipe4[i] = '0;
            pipe6[i] = '0;
            pipe8[i] = '0;
        end

        // Reset held two cycles with all-ones input, then released.
        step("rst0", 1'b1, 4'hF, 6'h3F, 8'hFF, 4'b0000, 4'b0000, 4'b0000);
        step("rst1", 1'b1, 4'hF, 6'h3F, 8'hFF, 4'b0000, 4'b0000, 4'b0000);
        step("rel0", 1'b0, 4'hF, 6'h3F, 8'hFF, 4'b1000, 4'b1000, 4'b1000);

        // Walking one from the MSB.
        step("walk0", 1'b0, 4'b1000, 6'b100000, 8'h80, 4'b1000, 4'b1000, 4'b1000);
        step("walk1", 1'b0, 4'b0100, 6'b010000, 8'h40, 4'b1001, 4'b1001, 4'b1001);
        step("walk2", 1'b0, 4'b0010, 6'b001000, 8'h20, 4'b1010, 4'b1010, 4'b1010);
        step("walk3", 1'b0, 4'b0001, 6'b000100, 8'h10, 4'b1011, 4'b1011, 4'b1011);

        // Zero inputs and lowest-bit extremes.
        step("zlo0", 1'b0, 4'b0000, 6'b000001, 8'h01, 4'b0000, 4'b1101, 4'b1111);
        step("zlo1", 1'b0, 4'b0011, 6'b000000, 8'h00, 4'b1010, 4'b0000, 4'b0000);
        step("mix0", 1'b0, 4'b0101, 6'b000011, 8'h05, 4'b1001, 4'b1100, 4'b1101);
        step("mix1", 1'b0, 4'b1111, 6'b011111, 8'h3C, 4'b1000, 4'b1001, 4'b1010);

        // One-cycle reset mid-stream.
        step("mid0", 1'b0, 4'b0001, 6'b000010, 8'h0F, 4'b1011, 4'b1100, 4'b1100);
        step("mid1", 1'b1, 4'b1000, 6'b100000, 8'h80, 4'b0000, 4'b0000, 4'b0000);
        step("mid2", 1'b0, 4'b0010, 6'b000010, 8'h02, 4'b1010, 4'b1100, 4'b1110);
        step("mid3", 1'b0, 4'b1000, 6'b001111, 8'h7F, 4'b1000, 4'b1010, 4'b1001);
        step("mid4", 1'b0, 4'b0110, 6'b110000, 8'h08, 4'b1001, 4'b1000, 4'b1100);

        // Random stream, one new vector per cycle.
        for (int n = 0; n < 1000; n++) begin
            x4 = 4'($urandom);
            x6 = 6'($urandom);
            x8 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) x8 = 8'h00;
            if ($urandom_range(0, 7) == 0) x8 = x8 >> $urandom_range(1, 7);
            step("rand", 1'b0, x4, x6, x8,
                 ref_clz({4'b0, x4}, 4), ref_clz({2'b0, x6}, 6), ref_clz(x8, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clz_clk.md
Name: clz_clk

Overview:
- Registered count-leading-zeros unit.
- Takes a `bits_in`-wide vector and, one clock later, reports:
  - the number of zeros above the most-significant set bit;
  - a flag saying whether any bit was set.
- Used by the uniform-to-float converter to turn the exponent field of a uniform random word into a geometric exponent; its `vout` drives the float-valid path.

Parameters:
- `bits_in`, default 8: input width. Must be even and ≥ 2; need not be a power of two.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `b`, input, `bits_in`: vector to scan. Bit `bits_in-1` is the leading (MSB) position.
- `vout`, output, 1: registered; 1 when the sampled `b` had at least one bit set.
- `pout`, output, `clog2(bits_in)`: registered leading-zero count of the sampled `b`.

Behaviour:
- Reset: at a rising edge with `rst`=1, `vout`←0 and `pout`←0. `b` is ignored that cycle. Reset dominates every other condition.
- Normal operation, every rising edge with `rst`=0:
  - `vout` ← OR-reduction of `b`.
  - `pout` ← number of consecutive zeros starting at `b[bits_in-1]` and going down to the first 1.
- Latency is exactly 1 cycle: the output at edge n+1 reflects `b` sampled at edge n.
- Throughput is one result per cycle, no stall, no enable, no handshake. A new `b` may change every cycle.
- Count range: 0 … `bits_in-1`, which always fits in `clog2(bits_in)` bits.
- All-zero input: `vout`=0 and `pout`=0. The true count `bits_in` is not representable; consumers must qualify `pout` with `vout`.
- Non-power-of-two widths:
  - Internally pad `b` at the LSB end with zeros up to the next power of two P.
  - Compute the count over P bits with a log2(P)-level tree.
  - Truncate to `clog2(bits_in)` bits. Padding zeros never affect a nonzero result.
- Datapath:
  - Purely combinational tree feeding a single output register stage.
  - No state other than the output registers, with no exceptions.
- Reset deasserted mid-stream: the first edge after deassertion registers the current `b` normally.

Optional Feature:
- Macro: `CLZ_CLK_PIPE_EN`.
- When defined:
  - Insert one additional register stage between the halves of the tree, at the level nearest log2(P)/2.
  - Latency becomes 2 cycles.
  - `rst` clears both stages, so `vout`=0 for the two edges following reset deassertion unless `b` is nonzero.
- When undefined: latency is 1 cycle as specified above. This is the default; the float converter relies on it.

Decomposition:
- Shared package `clz_pkg`:
  - `clog2` constant function;
  - `next_pow2` function;
  - localparam for the padded width P.
- One sub-module, `clz_node`, purely combinational. It merges two halves, each with a valid flag and an m-bit count, into a valid flag and an (m+1)-bit count:
  - `v = vl | vr`;
  - `count = vl ? {0, cl} : {1, cr}`.
- Generate-loop instances of `clz_node` form the tree.
- Leaf level operates on 2-bit pairs: `v = |pair`, `count = ~pair[1]`.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles with `b`=all ones → `vout`=0, `pout`=0 throughout. Release; the next edge gives `vout`=1, `pout`=0.
- `bits_in`=4, stream `b`=1000, 0100, 0010, 0001 on consecutive cycles → one cycle later each: `pout`=0, 1, 2, 3 with `vout`=1.
- `bits_in`=4, `b`=0000 → `vout`=0, `pout`=0; then `b`=0011 → `vout`=1, `pout`=2 the following cycle.
- `bits_in`=6 (non-power-of-two), `b`=000001 → `pout`=5 (3 bits), `vout`=1; `b`=000000 → `vout`=0.
- `bits_in`=8, random `b` each cycle for 1000 cycles → `pout` and `vout` match a reference model delayed by exactly 1 cycle (2 cycles with `CLZ_CLK_PIPE_EN`).
- Assert `rst` mid-stream for 1 cycle → outputs 0 at that edge; valid results resume on the next edge with no stale data.
